// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types used by the memory arbiter slice.
// Contents:
//   ramstate_t : RAM port status (FREE, BUSY, ACCESS, ERROR)
//   word_t     : native 32-bit machine word
//   src_id_t   : arbiter source id, encoded {core, is_data}
//   make_src   : builds a source id from core index and class
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ISRC0 = 2'b00,
        DSRC0 = 2'b01,
        ISRC1 = 2'b10,
        DSRC1 = 2'b11
    } src_id_t;

    function automatic src_id_t make_src(input logic core, input logic is_data);
        return src_id_t'({core, is_data});
    endfunction

endpackage

// File: rtl/dual_core_mem_arbiter_if.sv
// Bus bundle between the two cores' caches, the arbiter and the RAM model.
// Cache side : iREN/iaddr -> iwait/iload, dREN/dWEN/daddr/dstore -> dwait/dload
// RAM side   : ramREN/ramWEN/ramaddr/ramstore -> ramload/ramstate
// Status     : timeout_err (sticky)
// Modports   : slave  = the arbiter
//              master = caches + RAM model (the environment around the arbiter)
interface dual_core_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import cpu_types_pkg::*;

    logic [1:0]             iREN;
    logic [1:0][ADDR_W-1:0] iaddr;
    logic [1:0]             iwait;
    logic [DATA_W-1:0]      iload;

    logic [1:0]             dREN;
    logic [1:0]             dWEN;
    logic [1:0][ADDR_W-1:0] daddr;
    logic [1:0][DATA_W-1:0] dstore;
    logic [1:0]             dwait;
    logic [DATA_W-1:0]      dload;

    logic                   ramREN;
    logic                   ramWEN;
    logic [ADDR_W-1:0]      ramaddr;
    logic [DATA_W-1:0]      ramstore;
    logic [DATA_W-1:0]      ramload;
    ramstate_t              ramstate;

    logic                   timeout_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err
    );

endinterface

// File: rtl/mem_arb_priority.sv
// Combinational winner selection for the shared RAM port.
// Inputs : ireq[1:0] instruction requests, dreq[1:0] data requests (read or write),
//          rr_core    core that gets first pick within a class
// Outputs: winner     source id {core, is_data}, valid when any request is pending
// Data requests always beat instruction requests.
module mem_arb_priority
    import cpu_types_pkg::*;
(
    input  logic [1:0] ireq,
    input  logic [1:0] dreq,
    input  logic       rr_core,
    output src_id_t    winner,
    output logic       valid
);

    logic other_core;

    assign other_core = ~rr_core;

    always_comb begin
        winner = ISRC0;
        valid  = 1'b1;
        if (dreq[rr_core]) begin
            winner = make_src(rr_core, 1'b1);
        end else if (dreq[other_core]) begin
            winner = make_src(other_core, 1'b1);
        end else if (ireq[rr_core]) begin
            winner = make_src(rr_core, 1'b0);
        end else if (ireq[other_core]) begin
            winner = make_src(other_core, 1'b0);
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// Arbiter for the single shared RAM port between both cores' icache and dcache.
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : dual_core_mem_arbiter_if.slave (cache requests/waits, RAM strobes/response,
//          sticky timeout_err)
// One transaction at a time: IDLE picks a winner, XFER drives the RAM from the owner's
// live request until ACCESS (complete), ERROR (retry via re-arbitration) or request drop
// (abort). The RAM response is steered back to the owner only in its ACCESS cycle.
module dual_core_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input logic CLK,
    input logic RST,
    dual_core_mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic {
        StIdle,
        StXfer
    } state_t;

    state_t           state_q, state_d;
    src_id_t          owner_q, owner_d;
    logic             rr_core_q, rr_core_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic [1:0]        dreq;
    src_id_t           win_id;
    logic              win_valid;
    logic              own_core;
    logic              own_data;
    logic              own_req;
    logic              ack;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic [1:0]        iwait_v;
    logic [1:0]        dwait_v;

    assign dreq     = bus.dREN | bus.dWEN;
    assign own_core = owner_q[1];
    assign own_data = owner_q[0];
    assign own_req  = own_data ? dreq[own_core] : bus.iREN[own_core];

    mem_arb_priority u_priority (
        .ireq    (bus.iREN),
        .dreq    (dreq),
        .rr_core (rr_core_q),
        .winner  (win_id),
        .valid   (win_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            owner_q    <= ISRC0;
            rr_core_q  <= 1'b0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_core_q  <= rr_core_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_core_d  = rr_core_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        ack        = 1'b0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_store  = '0;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d    = StXfer;
                    owner_d    = win_id;
                    wait_cnt_d = '0;
                end
            end
            StXfer: begin
                // Strobes follow the owner's live request so a dropped request
                // deasserts the RAM strobe in the same cycle.
                ram_addr  = own_data ? bus.daddr[own_core] : bus.iaddr[own_core];
                ram_store = own_data ? bus.dstore[own_core] : '0;
                ram_ren   = own_data ? bus.dREN[own_core] : bus.iREN[own_core];
                ram_wen   = own_data & bus.dWEN[own_core];

                if (!own_req) begin
                    // Abort takes precedence: never hand back data nobody waits for.
                    state_d = StIdle;
                end else begin
                    case (bus.ramstate)
                        ACCESS: begin
                            ack       = 1'b1;
                            state_d   = StIdle;
                            rr_core_d = ~own_core;
                        end
                        ERROR: begin
                            state_d = StIdle;
                        end
                        default: begin
                            if (wait_cnt_q != CNT_MAX) begin
                                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                            end
                            if (wait_cnt_d == CNT_MAX) begin
                                timeout_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        iwait_v = '0;
        dwait_v = '0;
        for (int k = 0; k < 2; k++) begin
            iwait_v[k] = bus.iREN[k] & ~(ack & ~own_data & (own_core == 1'(k)));
            dwait_v[k] = dreq[k] & ~(ack & own_data & (own_core == 1'(k)));
        end
    end

    assign bus.iwait       = iwait_v;
    assign bus.dwait       = dwait_v;
    assign bus.iload       = (ack & ~own_data) ? bus.ramload : '0;
    assign bus.dload       = (ack & own_data) ? bus.ramload : '0;
    assign bus.ramREN      = ram_ren;
    assign bus.ramWEN      = ram_wen;
    assign bus.ramaddr     = ram_addr;
    assign bus.ramstore    = ram_store;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Bench for dual_core_mem_arbiter: directed stimulus, a transaction-level reference
// model checked every cycle, plus literal expectations for each scenario.
module tb_dual_core_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned MaxWait = 4;

    logic clk;
    logic rst;

    dual_core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dual_core_mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MaxWait)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          acks[$];

    // Reference model: current transaction (if any), round-robin pointer, wait count.
    int m_xfer, m_owner, m_rr, m_cnt;
    bit m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [3:0]  req;
        logic [3:0]  dut_w;
        logic [3:0]  exp_w;
        logic        e_ren, e_wen, ack;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        int          c, d, cand;
        bit          found;

        // Source index s = core*2 + is_data.
        req   = {bus.dREN[1] | bus.dWEN[1], bus.iREN[1], bus.dREN[0] | bus.dWEN[0], bus.iREN[0]};
        dut_w = {bus.dwait[1], bus.iwait[1], bus.dwait[0], bus.iwait[0]};
        if (rst) begin
            m_xfer = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_to = 0;
        end
        c = m_owner / 2;
        d = m_owner % 2;
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; ack = 0;
        if (m_xfer != 0) begin
            e_addr  = (d == 1) ? bus.daddr[c] : bus.iaddr[c];
            e_store = (d == 1) ? bus.dstore[c] : 32'h0;
            e_ren   = (d == 1) ? bus.dREN[c] : bus.iREN[c];
            e_wen   = (d == 1) ? bus.dWEN[c] : 1'b0;
            ack     = req[m_owner] && (bus.ramstate == ACCESS);
        end
        for (int s = 0; s < 4; s++) exp_w[s] = req[s] && !(ack && s == m_owner);
        e_iload = (ack && d == 0) ? bus.ramload : 32'h0;
        e_dload = (ack && d == 1) ? bus.ramload : 32'h0;

        check("m_ramREN", 32'(bus.ramREN), 32'(e_ren));
        check("m_ramWEN", 32'(bus.ramWEN), 32'(e_wen));
        check("m_ramaddr", bus.ramaddr, e_addr);
        check("m_ramstore", bus.ramstore, e_store);
        check("m_waits", 32'(dut_w), 32'(exp_w));
        check("m_iload", bus.iload, e_iload);
        check("m_dload", bus.dload, e_dload);
        check("m_timeout", 32'(bus.timeout_err), 32'(m_to));

        for (int s = 0; s < 4; s++) if (req[s] && !dut_w[s]) acks.push_back(s);

        if (!rst) begin
            if (m_xfer == 0) begin
                found = 0;
                for (int cls = 1; cls >= 0; cls--) begin
                    for (int k = 0; k < 2; k++) begin
                        cand = ((k == 0) ? m_rr : 1 - m_rr) * 2 + cls;
                        if (!found && req[cand]) begin
                            found   = 1;
                            m_owner = cand;
                        end
                    end
                end
                if (found) begin
                    m_xfer = 1;
                    m_cnt  = 0;
                end
            end else if (!req[m_owner]) begin
                m_xfer = 0;
            end else if (bus.ramstate == ACCESS) begin
                m_xfer = 0;
                m_rr   = 1 - c;
            end else if (bus.ramstate == ERROR) begin
                m_xfer = 0;
            end else begin
                if (m_cnt < MaxWait) m_cnt++;
                if (m_cnt >= MaxWait) m_to = 1;
            end
        end
    end

    task automatic clear_inputs();
        bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    endtask

    task automatic to_neg();
        @(negedge clk); #1;
    endtask

    task automatic to_pos();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        to_pos();
        rst = 1'b0;
        acks.delete();
    endtask

    task automatic check_acks(input string name, input int n, input int e0, input int e1,
                              input int e2, input int e3, input int e4, input int e5);
        int exp_l[6];
        exp_l = '{e0, e1, e2, e3, e4, e5};
        check({name, "_count"}, 32'(acks.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check({name, "_grant"}, (i < acks.size()) ? 32'(acks[i]) : 32'hFFFF_FFFF,
                  32'(exp_l[i]));
        end
    endtask

    initial begin
        int wen_cycles;
        int lat;
        rst = 1'b1;
        clear_inputs();
        bus.iREN = 2'b01;
        #1;
        check("rst_ramREN", 32'(bus.ramREN), 32'h0);
        check("rst_ramaddr", bus.ramaddr, 32'h0);
        check("rst_timeout", 32'(bus.timeout_err), 32'h0);
        check("rst_iwait", 32'(bus.iwait), 32'h1);
        to_pos();
        to_pos();

        // Single read, immediate ACCESS.
        do_reset();
        bus.iREN = 2'b01; bus.iaddr[0] = 32'h100;
        to_neg();
        check("t1_c0_iwait0", 32'(bus.iwait[0]), 32'h1);
        check("t1_c0_ramREN", 32'(bus.ramREN), 32'h0);
        to_pos();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEAD_BEEF;
        to_neg();
        check("t1_c1_iwait0", 32'(bus.iwait[0]), 32'h0);
        check("t1_c1_iload", bus.iload, 32'hDEAD_BEEF);
        check("t1_c1_ramaddr", bus.ramaddr, 32'h100);
        check("t1_c1_ramREN", 32'(bus.ramREN), 32'h1);
        to_pos();
        clear_inputs();
        to_pos();

        // Data beats instruction; rr_core follows completions.
        do_reset();
        bus.iREN = 2'b11; bus.dREN = 2'b10; bus.ramstate = ACCESS;
        bus.iaddr[0] = 32'h200; bus.iaddr[1] = 32'h204; bus.daddr[1] = 32'h300;
        bus.ramload = 32'h5555_AAAA;
        for (int cyc = 0; cyc < 6; cyc++) begin
            to_pos();
            if (cyc == 1) bus.dREN = 2'b00;
            if (cyc == 3) bus.iREN[0] = 1'b0;
            if (cyc == 5) bus.iREN[1] = 1'b0;
        end
        check_acks("t2", 3, 3, 0, 2, 0, 0, 0);
        clear_inputs();
        to_pos();

        // Round robin between both dcaches.
        do_reset();
        bus.dREN = 2'b11; bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h20;
        bus.ramstate = ACCESS; bus.ramload = 32'h0BAD_F00D;
        repeat (12) to_pos();
        check_acks("t3", 6, 1, 3, 1, 3, 1, 3);
        clear_inputs();
        to_pos();

        // Write path: 3 BUSY cycles then ACCESS.
        do_reset();
        bus.dWEN = 2'b10; bus.daddr[1] = 32'h2000; bus.dstore[1] = 32'h1234_5678;
        wen_cycles = 0;
        lat = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            bus.ramstate = (cyc == 0) ? FREE : ((cyc < 4) ? BUSY : ACCESS);
            to_neg();
            if (bus.ramWEN && bus.ramaddr == 32'h2000 && bus.ramstore == 32'h1234_5678)
                wen_cycles++;
            if (lat == 0 && !bus.dwait[1]) lat = cyc + 1;
            check("t4_dwait1", 32'(bus.dwait[1]), (cyc == 4) ? 32'h0 : 32'h1);
            to_pos();
        end
        check("t4_wen_cycles", 32'(wen_cycles), 32'd4);
        check("t4_latency", 32'(lat), 32'd5);
        clear_inputs();
        to_pos();

        // ERROR then retry with ACCESS.
        do_reset();
        bus.dREN = 2'b01; bus.daddr[0] = 32'h40; bus.ramload = 32'hCAFE_0001;
        for (int cyc = 0; cyc < 4; cyc++) begin
            bus.ramstate = (cyc == 1) ? ERROR : ((cyc == 3) ? ACCESS : FREE);
            to_neg();
            check("t5_dwait0", 32'(bus.dwait[0]), (cyc == 3) ? 32'h0 : 32'h1);
            to_pos();
        end
        check_acks("t5", 1, 1, 0, 0, 0, 0, 0);
        clear_inputs();
        to_pos();

        // Abort: dREN dropped mid-BUSY, then rr_core must be unchanged.
        do_reset();
        bus.dREN = 2'b10; bus.daddr[1] = 32'h80; bus.ramload = 32'hBAD0_BAD0;
        bus.ramstate = FREE;
        to_pos();
        bus.ramstate = BUSY;
        to_pos();
        to_pos();
        bus.dREN = 2'b00; bus.ramstate = ACCESS;
        to_neg();
        check("t6_c3_dload", bus.dload, 32'h0);
        check("t6_c3_ramREN", 32'(bus.ramREN), 32'h0);
        to_pos();
        bus.iREN = 2'b11;
        to_neg();
        check("t6_c4_ramREN", 32'(bus.ramREN), 32'h0);
        to_pos();
        to_neg();
        check("t6_c5_iwait", 32'(bus.iwait), 32'h2);
        to_pos();
        check_acks("t6", 1, 0, 0, 0, 0, 0, 0);
        clear_inputs();
        to_pos();

        // Timeout after MaxWait BUSY cycles, then asynchronous reset mid-XFER.
        do_reset();
        bus.iREN = 2'b01; bus.iaddr[0] = 32'h500;
        to_pos();
        bus.ramstate = BUSY;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            to_neg();
            check("t7_timeout", 32'(bus.timeout_err), (cyc == 5) ? 32'h1 : 32'h0);
            to_pos();
        end
        #2;
        check("t7_pre_ramREN", 32'(bus.ramREN), 32'h1);
        rst = 1'b1;
        #1;
        check("t7_rst_ramREN", 32'(bus.ramREN), 32'h0);
        check("t7_rst_ramaddr", bus.ramaddr, 32'h0);
        check("t7_rst_timeout", 32'(bus.timeout_err), 32'h0);
        check("t7_rst_iwait0", 32'(bus.iwait[0]), 32'h1);
        to_pos();
        rst = 1'b0;
        clear_inputs();
        repeat (2) to_pos();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
